// File: rtl/alu_seq_param.sv
// alu_seq_param: width-generic ALU between the register file/DMAC front end
// and the result registers. Logic, shift, add and sub complete in one cycle;
// multiply (opcode F) is an iterative shift-add over WIDTH cycles with a
// busy/op_done handshake. Operands are latched at start, so the inputs may
// change while a multiply runs.
// Optional feature macro: ALU_SIGNED_MUL_EN -- when defined, opcode F is a
// two's-complement multiply with one extra sign fix-up cycle (latency
// WIDTH+1); when undefined, opcode F is unsigned with latency WIDTH.
module alu_seq_param #(
  parameter int WIDTH   = 32,
  parameter int SHIFT_W = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         op_code,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [WIDTH-1:0]   operand_1,
  input  logic [WIDTH-1:0]   operand_2,
  input  logic               op_start,
  input  logic               op_clear,
  output logic [WIDTH-1:0]   result_hi,
  output logic [WIDTH-1:0]   result_lo,
  output logic               op_done,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'hF;

`ifdef ALU_SIGNED_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [WIDTH-1:0]     a_lat, a_lat_nxt;
  logic [WIDTH-1:0]     b_lat, b_lat_nxt;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]     res_hi, res_hi_nxt;
  logic [WIDTH-1:0]     res_lo, res_lo_nxt;
  logic                 done_r, done_nxt;
  logic                 busy_r, busy_nxt;
`ifdef ALU_SIGNED_MUL_EN
  logic                 neg_r, neg_nxt;
`endif

  // single-cycle datapath
  logic [WIDTH-1:0]     alu_hi, alu_lo;
  logic [WIDTH:0]       add_full;
  // multiply step
  logic [2*WIDTH-1:0]   a_ext, partial, acc_sum;

  assign result_hi = res_hi;
  assign result_lo = res_lo;
  assign op_done   = done_r;
  assign busy      = busy_r;

  // One-cycle result for opcodes 0..E; opcode F is handled by the FSM.
  always_comb begin
    alu_hi   = '0;
    alu_lo   = '0;
    add_full = {1'b0, operand_1} + {1'b0, operand_2};
    case (op_code)
      4'h0: alu_lo = '0;
      4'h1: alu_lo = ~operand_1;
      4'h2: alu_lo = ~operand_2;
      4'h3: alu_lo = operand_1 & operand_2;
      4'h4: alu_lo = operand_1 | operand_2;
      4'h5: alu_lo = operand_1 ^ operand_2;
      4'h6: alu_lo = ~(operand_1 ^ operand_2);
      4'h7: alu_lo = operand_1 << shift;
      4'h8: alu_lo = operand_1 >> shift;
      4'h9: alu_lo = WIDTH'($signed(operand_1) >>> shift);
      4'hA: alu_lo = operand_2 << shift;
      4'hB: alu_lo = operand_2 >> shift;
      4'hC: alu_lo = WIDTH'($signed(operand_2) >>> shift);
      4'hD: begin
        alu_lo = add_full[WIDTH-1:0];
        alu_hi = {{(WIDTH-1){1'b0}}, add_full[WIDTH]};
      end
      4'hE: begin
        alu_lo = operand_1 - operand_2;
        alu_hi = {WIDTH{(operand_1 < operand_2)}};
      end
      default: begin
        alu_lo = '0;
        alu_hi = '0;
      end
    endcase
  end

  // Shift-add step: accumulate A<<cnt when bit cnt of B is set.
  always_comb begin
    a_ext   = {{WIDTH{1'b0}}, a_lat};
    partial = b_lat[cnt] ? (a_ext << cnt) : '0;
    acc_sum = acc + partial;
  end

  // Next-state and next-output logic; clear overrides everything, including
  // a simultaneous start.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    a_lat_nxt  = a_lat;
    b_lat_nxt  = b_lat;
    acc_nxt    = acc;
    res_hi_nxt = res_hi;
    res_lo_nxt = res_lo;
    done_nxt   = done_r;
    busy_nxt   = busy_r;
`ifdef ALU_SIGNED_MUL_EN
    neg_nxt    = neg_r;
`endif
    if (op_clear) begin
      state_nxt  = S_IDLE;
      cnt_nxt    = '0;
      res_hi_nxt = '0;
      res_lo_nxt = '0;
      done_nxt   = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (op_start) begin
            if (op_code == OP_MUL) begin
`ifdef ALU_SIGNED_MUL_EN
              // core works on magnitudes; the sign is restored in S_FIX
              a_lat_nxt = operand_1[WIDTH-1] ? -operand_1 : operand_1;
              b_lat_nxt = operand_2[WIDTH-1] ? -operand_2 : operand_2;
              neg_nxt   = operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
`else
              a_lat_nxt = operand_1;
              b_lat_nxt = operand_2;
`endif
              acc_nxt   = '0;
              cnt_nxt   = '0;
              busy_nxt  = 1'b1;
              done_nxt  = 1'b0;
              state_nxt = S_MUL;
            end else begin
              res_hi_nxt = alu_hi;
              res_lo_nxt = alu_lo;
              done_nxt   = 1'b1;
              state_nxt  = S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_nxt = acc_sum;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            cnt_nxt = '0;
`ifdef ALU_SIGNED_MUL_EN
            state_nxt = S_FIX;
`else
            // product goes straight to the ports; partials never do
            {res_hi_nxt, res_lo_nxt} = acc_sum;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = S_DONE;
`endif
          end
        end
`ifdef ALU_SIGNED_MUL_EN
        S_FIX: begin
          {res_hi_nxt, res_lo_nxt} = neg_r ? -acc : acc;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_DONE;
        end
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      acc    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
`ifdef ALU_SIGNED_MUL_EN
      neg_r  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      a_lat  <= a_lat_nxt;
      b_lat  <= b_lat_nxt;
      acc    <= acc_nxt;
      res_hi <= res_hi_nxt;
      res_lo <= res_lo_nxt;
      done_r <= done_nxt;
      busy_r <= busy_nxt;
`ifdef ALU_SIGNED_MUL_EN
      neg_r  <= neg_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param: directed cases plus randomized ops checked
// against an arithmetic reference model. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_alu_seq_param;
  localparam int W  = 32;
  localparam int SW = 2;
`ifdef ALU_SIGNED_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = W;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    op_code;
  logic [SW-1:0] shift;
  logic [W-1:0]  operand_1, operand_2;
  logic          op_start, op_clear;
  logic [W-1:0]  result_hi, result_lo;
  logic          op_done, busy;

  int checks = 0;
  int errors = 0;

  alu_seq_param #(.WIDTH(W), .SHIFT_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .op_code(op_code), .shift(shift),
    .operand_1(operand_1), .operand_2(operand_2), .op_start(op_start),
    .op_clear(op_clear), .result_hi(result_hi), .result_lo(result_lo),
    .op_done(op_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Expected {hi,lo} from plain arithmetic on the operation's definition.
  function automatic logic [2*W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input int sh);
    logic [W-1:0] hi, lo, src;
    hi = '0;
    lo = '0;
    src = (op >= 4'hA) ? b : a;
    case (op)
      4'h1: lo = ~a;
      4'h2: lo = ~b;
      4'h3: lo = a & b;
      4'h4: lo = a | b;
      4'h5: lo = a ^ b;
      4'h6: lo = ~(a ^ b);
      4'h7, 4'hA: lo = src << sh;
      4'h8, 4'hB: lo = src >> sh;
      4'h9, 4'hC: begin
        lo = src >> sh;
        if (src[W-1]) for (int i = 0; i < sh; i++) lo[W-1-i] = 1'b1;
      end
      4'hD: return {{W{1'b0}}, a} + {{W{1'b0}}, b};
      4'hE: begin
        lo = a - b;
        hi = (a < b) ? '1 : '0;
      end
`ifdef ALU_SIGNED_MUL_EN
      4'hF: return $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
`else
      4'hF: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
      default: ;
    endcase
    return {hi, lo};
  endfunction

  // Issue one op; for multiply, scramble inputs and poke op_start mid-run.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int sh);
    logic [2*W-1:0] exp;
    int n;
    exp = ref_op(op, a, b, sh);
    @(negedge clk);
    op_code = op; operand_1 = a; operand_2 = b; shift = SW'(sh); op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    if (op != 4'hF) begin
      chk({tag, "_res"}, {result_hi, result_lo}, exp);
      chk({tag, "_done"}, 64'(op_done), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
    end else begin
      chk({tag, "_busy1"}, 64'(busy), 64'd1);
      chk({tag, "_done0"}, 64'(op_done), 64'd0);
      n = 0;
      while (!op_done && n < 4 * W) begin
        operand_1 = $urandom; operand_2 = $urandom;
        op_code = 4'($urandom); shift = SW'($urandom);
        op_start = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        n++;
      end
      op_start = 1'b0;
      chk({tag, "_lat"}, 64'(n), 64'(MUL_LAT));
      chk({tag, "_res"}, {result_hi, result_lo}, exp);
      chk({tag, "_busy0"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    reset_n = 1'b0; op_code = '0; shift = '0; operand_1 = '0; operand_2 = '0;
    op_start = 1'b0; op_clear = 1'b0;
    #1;
    chk("rst_res", {result_hi, result_lo}, 64'd0);
    chk("rst_done", 64'(op_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("xor", 4'h5, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op("asra", 4'h9, 32'h8000_0010, 32'h0, 3);
    run_op("add_c", 4'hD, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("sub_b", 4'hE, 32'h1, 32'h2, 0);
    run_op("mul_ff", 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mul_z", 4'hF, 32'h0, 32'h1234_5678, 0);
    run_op("nop", 4'h0, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // clear mid-multiply
    @(negedge clk);
    op_code = 4'hF; operand_1 = 32'd3; operand_2 = 32'd5; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (9) @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    chk("clr_res", {result_hi, result_lo}, 64'd0);
    chk("clr_done", 64'(op_done), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    // clear and start together: start dropped
    op_clear = 1'b1; op_start = 1'b1; op_code = 4'h4;
    operand_1 = 32'hDEAD_BEEF; operand_2 = 32'h1;
    @(negedge clk);
    op_clear = 1'b0; op_start = 1'b0;
    @(negedge clk);
    chk("clrst_res", {result_hi, result_lo}, 64'd0);
    chk("clrst_done", 64'(op_done), 64'd0);
    chk("clrst_busy", 64'(busy), 64'd0);

    // async reset mid-multiply, with nonzero results held beforehand
    run_op("or", 4'h4, 32'h0F0F_0000, 32'h0000_00F0, 0);
    @(negedge clk);
    op_code = 4'hF; operand_1 = '1; operand_2 = '1; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_res", {result_hi, result_lo}, 64'd0);
    chk("arst_done", 64'(op_done), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("mul_76", 4'hF, 32'd7, 32'd6, 0);
`ifdef ALU_SIGNED_MUL_EN
    run_op("smul", 4'hF, 32'hFFFF_FFFE, 32'd3, 0);
    run_op("smul_nn", 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`endif

    // randomized ops, biased towards corner operands
    repeat (40) begin
      op = 4'($urandom);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: a = '0;
        1: b = '1;
        2: a = 32'h8000_0000;
        default: ;
      endcase
      run_op("rnd", op, a, b, $urandom_range(0, (1 << SW) - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, width-generic successor to the team's 16-op ALU.
- Logic, shift, add and sub ops complete in one cycle. Multiply is an iterative shift-add over WIDTH cycles with a busy/done handshake.
- Operands and opcode are latched at start, so the DMA side may change the inputs while a multiply is running.
- Sits between the register file/DMAC front end and the result registers.

Parameters:
- WIDTH, 32, operand width in bits (≥4); the product is 2*WIDTH.
- SHIFT_W, 2, width of the shift-amount input; shift range 0..2^SHIFT_W-1.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- op_code  in  4  operation select, sampled with op_start
- shift  in  SHIFT_W  shift amount, sampled with op_start
- operand_1  in  WIDTH  operand A, sampled with op_start
- operand_2  in  WIDTH  operand B, sampled with op_start
- op_start  in  1  start request; accepted only when not busy
- op_clear  in  1  synchronous abort/clear
- result_hi  out  WIDTH  upper result word
- result_lo  out  WIDTH  lower result word
- op_done  out  1  result valid; a level signal
- busy  out  1  multiply in progress

Behaviour:
- Reset (reset_n=0, async): result_hi=0, result_lo=0, op_done=0, busy=0, state IDLE, counter=0, internal latches=0.
- States: IDLE, MUL, DONE.
  - IDLE/DONE + op_start with op_code≠F: result registered at the same edge, op_done=1, state DONE. Latency 1 cycle.
  - IDLE/DONE + op_start with op_code=F: latch A, B; accumulator=0; counter=0; busy=1; op_done=0; state MUL.
  - MUL: each edge adds (B[counter] ? A<<counter : 0) to the 2*WIDTH accumulator and increments the counter. At the WIDTH-th MUL edge: {result_hi,result_lo}=product, op_done=1, busy=0, state DONE. op_done is visible WIDTH cycles after the start edge.
- Opcode map:
  - 0 NOP: both results 0.
  - 1 NOTA: lo=~A.
  - 2 NOTB: lo=~B.
  - 3 AND, 4 OR, 5 XOR, 6 XNOR: lo = A op B.
  - 7 LSLA, 8 LSRA, 9 ASRA: lo = A shifted by shift; ASR replicates A[WIDTH-1].
  - A LSLB, B LSRB, C ASRB: same on B.
  - D ADD: lo=A+B mod 2^WIDTH; hi={WIDTH-1 zeros, carry}.
  - E SUB: lo=A-B mod 2^WIDTH; hi={WIDTH{borrow}}, with borrow=1 iff A<B unsigned.
  - F MUL: {hi,lo}=A*B, unsigned.
  - For ops 0-C, hi=0.
- Handshake and boundary rules:
  - op_start in MUL is ignored; it does not restart the multiply or change the latches.
  - op_start in DONE starts a new op; op_done drops to 0 only if the new op is MUL, otherwise it stays 1 with the new result.
  - Results hold until the next completed op or a clear.
  - op_clear=1 in any state: results=0, op_done=0, busy=0, counter=0, state IDLE.
  - op_clear and op_start in the same cycle: clear wins and the start is dropped.
  - Input changes during MUL have no effect on the result.
  - Multiply with A=0 or B=0 still takes WIDTH cycles.
  - Reset asserted mid-MUL: immediate return to reset values. No partial product is ever visible on the result ports.

Optional Feature:
- Macro ALU_SIGNED_MUL_EN.
- Defined: opcode F treats A and B as two's complement. The core multiplies magnitudes, then negates the 2*WIDTH product when the signs differ; this costs one extra fix-up cycle, so latency is WIDTH+1. Example: -1*-1 = 1.
- Undefined: opcode F is unsigned with latency WIDTH; no sign logic is synthesised.

Test Plan (WIDTH=32, SHIFT_W=2, macro undefined unless noted):
- Reset, then op_start with op_code=5, A=F0F0_F0F0, B=FF00_FF00 -> next edge lo=0F F0 0F F0 (0FF0_0FF0), hi=0, op_done=1, busy=0.
- op_code=9, A=8000_0010, shift=3 -> lo=F000_0002, hi=0. op_code=D, A=FFFF_FFFF, B=1 -> lo=0, hi=1. op_code=E, A=1, B=2 -> lo=FFFF_FFFF, hi=FFFF_FFFF.
- op_code=F, A=FFFF_FFFF, B=FFFF_FFFF -> busy=1 for 32 cycles, then hi=FFFF_FFFE, lo=0000_0001, op_done=1. Inputs toggled mid-run have no effect. A second op_start mid-run is ignored.
- MUL A=3, B=5, with op_clear at cycle 10 -> busy=0, op_done=0, results=0 next edge. A later clear+start in the same cycle -> remains IDLE.
- reset_n pulled low mid-MUL -> all outputs 0 asynchronously. A new MUL 7*6 after release -> lo=42 (0x2A), hi=0, after 32 cycles.
- ALU_SIGNED_MUL_EN defined: A=FFFF_FFFE (-2), B=3 -> after 33 cycles hi=FFFF_FFFF, lo=FFFF_FFFA (-6).
